// File: rtl/dbp_gen.sv
// Push-button debouncer: 2-flop synchronizer feeding a qualification FSM that
// emits a debounced level plus single-cycle press/release pulses.
module dbp_gen #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic dbp_clk,
  input  logic dbp_rst,
  input  logic dbp_btn,
  output logic dbp_level,
  output logic dbp_press,
  output logic dbp_rel
);

  // state  | meaning
  // IDLE   | debounced level low, input agrees
  // ARM_HI | input high, counting stable samples toward a press
  // HIGH   | debounced level high, input agrees
  // ARM_LO | input low, counting stable samples toward a release
  typedef enum logic [1:0] {IDLE, ARM_HI, HIGH, ARM_LO} state_e;

  localparam logic [19:0] CNT_LAST = 20'(DB_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        btn_s;
  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        rel_q, rel_d;

  assign btn_s = sync_q[1];

  always_ff @(posedge dbp_clk or negedge dbp_rst) begin
    if (!dbp_rst) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], dbp_btn};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_s) state_d = ARM_HI;
      end
      ARM_HI: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      HIGH: begin
        cnt_d = '0;
        if (!btn_s) state_d = ARM_LO;
      end
      ARM_LO: begin
        if (btn_s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Level follows the accepted side of the FSM, registered with the state.
    level_d = (state_d == HIGH) || (state_d == ARM_LO);
  end

  assign dbp_level = level_q;
  assign dbp_press = press_q;
  assign dbp_rel   = rel_q;

endmodule

// File: tb/tb_dbp_gen.sv
// Bench for dbp_gen: run-length debounce model checked every cycle, plus
// directed scenarios with hand-computed edge numbers for pulses and level.
module tb_dbp_gen;
  localparam int DB = 4;

  logic dbp_clk = 1'b0;
  logic dbp_rst = 1'b0;
  logic dbp_btn = 1'b0;
  logic dbp_level, dbp_press, dbp_rel;

  dbp_gen #(.DB_CYCLES(DB)) dut (
    .dbp_clk  (dbp_clk),
    .dbp_rst  (dbp_rst),
    .dbp_btn  (dbp_btn),
    .dbp_level(dbp_level),
    .dbp_press(dbp_press),
    .dbp_rel  (dbp_rel)
  );

  always #5 dbp_clk = ~dbp_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a level change is accepted once the synchronized input has
  // disagreed with the accepted level on DB+1 consecutive FSM samples.
  logic m_s1, m_s2, m_level, m_press, m_rel;
  int   run;
  always @(posedge dbp_clk or negedge dbp_rst) begin
    if (!dbp_rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_rel = 0; run = 0;
    end else begin
      m_press = 0;
      m_rel   = 0;
      if (m_s2 != m_level) begin
        run++;
        if (run == DB + 1) begin
          m_level = ~m_level;
          if (m_level) m_press = 1; else m_rel = 1;
          run = 0;
        end
      end else begin
        run = 0;
      end
      m_s2 = m_s1;
      m_s1 = dbp_btn;
    end
  end

  int   edge_cnt = 0;
  always @(posedge dbp_clk) edge_cnt <= edge_cnt + 1;

  // Event log, sampled mid-cycle; edge_cnt then names the edge just passed.
  bit cmp_en = 0;
  int press_cnt, rel_cnt, first_press, first_rel, rise_edge, fall_edge, low_cycles, high_cycles;
  logic prev_level = 0;
  task automatic clear_log();
    press_cnt = 0; rel_cnt = 0; first_press = -1; first_rel = -1;
    rise_edge = -1; fall_edge = -1; low_cycles = 0; high_cycles = 0;
  endtask

  always @(negedge dbp_clk) begin
    if (cmp_en) begin
      check("level_vs_model", int'(dbp_level), int'(m_level));
      check("press_vs_model", int'(dbp_press), int'(m_press));
      check("rel_vs_model", int'(dbp_rel), int'(m_rel));
      check("press_rel_exclusive", int'(dbp_press & dbp_rel), 0);
    end
    if (dbp_press) begin
      press_cnt++;
      if (first_press < 0) first_press = edge_cnt;
    end
    if (dbp_rel) begin
      rel_cnt++;
      if (first_rel < 0) first_rel = edge_cnt;
    end
    if (dbp_level && !prev_level) rise_edge = edge_cnt;
    if (!dbp_level && prev_level) fall_edge = edge_cnt;
    if (dbp_level) high_cycles++; else low_cycles++;
    prev_level = dbp_level;
  end

  // Downstream counter enabled by dbp_press.
  logic [3:0] cnt4;
  bit         cnt4_clr = 0;
  always @(posedge dbp_clk) begin
    if (cnt4_clr) cnt4 <= 4'd0;
    else if (dbp_press) cnt4 <= cnt4 + 4'd1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge dbp_clk);
    #2;
  endtask

  int n;
  initial begin
    clear_log();
    cycles(2);
    check("reset_level", int'(dbp_level), 0);
    check("reset_press", int'(dbp_press), 0);
    check("reset_rel", int'(dbp_rel), 0);
    dbp_rst = 1;
    cmp_en  = 1;
    cycles(3);

    // Clean press, held 200 ns
    clear_log();
    dbp_btn = 1; n = edge_cnt + 1;
    cycles(20);
    check("clean_press_count", press_cnt, 1);
    check("clean_press_edge", first_press, n + 6);
    check("clean_level_edge", rise_edge, n + 6);

    // Clean release
    clear_log();
    dbp_btn = 0; n = edge_cnt + 1;
    cycles(15);
    check("release_count", rel_cnt, 1);
    check("release_edge", first_rel, n + 6);
    check("release_level_edge", fall_edge, n + 6);

    // Bounce 1,0,1,0 then held low
    clear_log();
    dbp_btn = 1; cycles(1);
    dbp_btn = 0; cycles(1);
    dbp_btn = 1; cycles(1);
    dbp_btn = 0; cycles(15);
    check("bounce_press", press_cnt, 0);
    check("bounce_rel", rel_cnt, 0);
    check("bounce_level_high", high_cycles, 0);

    // Release bounce from HIGH
    dbp_btn = 1; cycles(12);
    clear_log();
    dbp_btn = 0; cycles(2);
    dbp_btn = 1; cycles(15);
    check("relbounce_rel", rel_cnt, 0);
    check("relbounce_press", press_cnt, 0);
    check("relbounce_level_low", low_cycles, 0);
    dbp_btn = 0; cycles(15);

    // Reset mid-qualification with button held
    dbp_btn = 1; cycles(4);
    dbp_rst = 0; #1;
    check("rstmid_level", int'(dbp_level), 0);
    check("rstmid_press", int'(dbp_press), 0);
    #14 dbp_rst = 1;
    clear_log();
    n = edge_cnt + 1;
    cycles(12);
    check("rstmid_press_count", press_cnt, 1);
    check("rstmid_press_edge", first_press, n + 6);

    // Reset while HIGH: level drops at once, no release pulse
    clear_log();
    dbp_rst = 0; #1;
    check("rsthigh_level", int'(dbp_level), 0);
    dbp_btn = 0;
    #10 dbp_rst = 1;
    cycles(12);
    check("rsthigh_rel", rel_cnt, 0);

    // Three clean presses into the downstream counter
    cnt4_clr = 1; cycles(1); cnt4_clr = 0;
    repeat (3) begin
      dbp_btn = 1; cycles(12);
      dbp_btn = 0; cycles(12);
    end
    check("chained_count", int'(cnt4), 3);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
